// File: rtl/hazard_stall_ctrl.sv
// Stall decision for the D stage: shadow scoreboard of E/M/W results vs. D-stage operand use times,
// plus the HI/LO multiply/divide busy counter. stall is combinational; scoreboard and counter update each edge.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    output logic        stall,
    output logic        md_busy,
    output logic [1:0]  tnew_E
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_SLTIU   = 6'h0b;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2a;
    localparam logic [5:0] F_SLTU  = 6'h2b;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md;
    } shadow_t;

    shadow_t        sh_e, sh_m, sh_w, dec;
    logic [CW-1:0]  cnt;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       rs_need, rt_need;
    logic [1:0] rs_tuse, rt_tuse;
    logic       is_hilo, is_mult, is_div;
    logic       data_stall, md_stall;

    assign op    = IR_D[31:26];
    assign rs    = IR_D[25:21];
    assign rt    = IR_D[20:16];
    assign rd    = IR_D[15:11];
    assign funct = IR_D[5:0];

    always_comb begin
        dec     = '0;
        rs_need = 1'b0;
        rt_need = 1'b0;
        rs_tuse = 2'd0;
        rt_tuse = 2'd0;
        is_hilo = 1'b0;
        is_mult = 1'b0;
        is_div  = 1'b0;
        case (op)
            OP_SPECIAL: begin
                case (funct)
                    F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
                        dec.dst  = rd;
                        dec.tnew = 2'd1;
                        rs_need  = 1'b1;
                        rs_tuse  = 2'd1;
                        rt_need  = 1'b1;
                        rt_tuse  = 2'd1;
                    end
                    F_JR: rs_need = 1'b1;
                    F_JALR: begin
                        dec.dst = rd;
                        rs_need = 1'b1;
                    end
                    F_MFHI, F_MFLO: begin
                        dec.dst  = rd;
                        dec.tnew = 2'd1;
                        is_hilo  = 1'b1;
                    end
                    F_MTHI, F_MTLO: begin
                        rs_need = 1'b1;
                        rs_tuse = 2'd1;
                        is_hilo = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        dec.md  = 1'b1;
                        rs_need = 1'b1;
                        rs_tuse = 2'd1;
                        rt_need = 1'b1;
                        rt_tuse = 2'd1;
                        is_hilo = 1'b1;
                        is_mult = (funct == F_MULT) || (funct == F_MULTU);
                        is_div  = (funct == F_DIV) || (funct == F_DIVU);
                    end
                    default: ;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                dec.dst  = rt;
                dec.tnew = 2'd1;
                rs_need  = 1'b1;
                rs_tuse  = 2'd1;
            end
            OP_LUI: dec.dst = rt;
            OP_LW: begin
                dec.dst  = rt;
                dec.tnew = 2'd2;
                rs_need  = 1'b1;
                rs_tuse  = 2'd1;
            end
            OP_SW: begin
                rs_need = 1'b1;
                rs_tuse = 2'd1;
                rt_need = 1'b1;
                rt_tuse = 2'd2;
            end
            OP_BEQ: begin
                rs_need = 1'b1;
                rt_need = 1'b1;
            end
            OP_JAL: dec.dst = 5'd31;
            default: ;
        endcase
    end

    // A producer blocks a consumer only while its result is still further away than the consumer's use point.
    function automatic logic src_hit(input logic [4:0] src, input logic need, input logic [1:0] tuse,
                                     input shadow_t e, input shadow_t m);
        return need && (src != 5'd0) &&
               (((src == e.dst) && (e.tnew > tuse)) || ((src == m.dst) && (m.tnew > tuse)));
    endfunction

    assign data_stall = src_hit(rs, rs_need, rs_tuse, sh_e, sh_m) | src_hit(rt, rt_need, rt_tuse, sh_e, sh_m);
    assign md_stall   = is_hilo && (sh_e.md || md_busy);
    assign stall      = !reset && (data_stall || md_stall);
    assign md_busy    = (cnt != '0);
    assign tnew_E     = sh_e.tnew;

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_e <= '0;
            sh_m <= '0;
            sh_w <= '0;
            cnt  <= '0;
        end else begin
            sh_e <= stall ? shadow_t'('0) : dec;
            sh_m <= {sh_e.dst, (sh_e.tnew != 2'd0) ? (sh_e.tnew - 2'd1) : 2'd0, 1'b0};
            sh_w <= {sh_m.dst, 2'd0, 1'b0};
            if (!stall && is_mult) begin
                cnt <= CW'(MULT_CYCLES);
            end else if (!stall && is_div) begin
                cnt <= CW'(DIV_CYCLES);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // W is kept for scoreboard completeness; everything there is already forwardable.
    logic unused_bits;
    assign unused_bits = ^{IR_D[10:6], sh_w, sh_m.md};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: feeds instruction streams into D, holds them while the model says stall,
// and compares every cycle against a register-ready-time model.
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int NO     = 99;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ir  = 32'h0;
    logic        stall, md_busy;
    logic [1:0]  tnew_E;

    hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (rst),
        .IR_D   (ir),
        .stall  (stall),
        .md_busy(md_busy),
        .tnew_E (tnew_E)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_stall = 0;
    int n_busy = 0;
    bit chk_en = 0;

    // model: cycle index, cycle at which each register becomes usable at Tuse=0, HI/LO ready cycle
    int cyc = 0;
    int ready_at[32];
    int md_done = 0;
    int e_tnew = 0;
    bit m_stall = 0;

    logic [31:0] prog[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, IR_D %h)", nm, act, exp, cyc, ir);
        end
    endtask

    function automatic void decode(input logic [31:0] i, output int dst, output int tnew,
                                   output int trs, output int trt, output bit hilo, output int len);
        int op, fn;
        op = int'(i[31:26]);
        fn = int'(i[5:0]);
        dst = 0; tnew = 0; trs = NO; trt = NO; hilo = 0; len = 0;
        if (op == 0) begin
            case (fn)
                'h21, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2a, 'h2b: begin
                    dst = int'(i[15:11]); tnew = 1; trs = 1; trt = 1;
                end
                'h08: trs = 0;
                'h09: begin dst = int'(i[15:11]); trs = 0; end
                'h10, 'h12: begin dst = int'(i[15:11]); tnew = 1; hilo = 1; end
                'h11, 'h13: begin trs = 1; hilo = 1; end
                'h18, 'h19: begin trs = 1; trt = 1; hilo = 1; len = MULT_N; end
                'h1a, 'h1b: begin trs = 1; trt = 1; hilo = 1; len = DIV_N; end
                default: ;
            endcase
        end else begin
            case (op)
                'h09, 'h0a, 'h0b, 'h0c, 'h0d, 'h0e: begin dst = int'(i[20:16]); tnew = 1; trs = 1; end
                'h0f: dst = int'(i[20:16]);
                'h23: begin dst = int'(i[20:16]); tnew = 2; trs = 1; end
                'h2b: begin trs = 1; trt = 2; end
                'h04: begin trs = 0; trt = 0; end
                'h03: dst = 31;
                default: ;
            endcase
        end
    endfunction

    function automatic bit model_stall();
        int dst, tnew, trs, trt, len, rs, rt;
        bit hilo;
        if (rst) return 1'b0;
        decode(ir, dst, tnew, trs, trt, hilo, len);
        rs = int'(ir[25:21]);
        rt = int'(ir[20:16]);
        if (trs != NO && rs != 0 && cyc < ready_at[rs] - trs) return 1'b1;
        if (trt != NO && rt != 0 && cyc < ready_at[rt] - trt) return 1'b1;
        if (hilo && cyc < md_done) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int dst, tnew, trs, trt, len;
        bit hilo;
        if (rst) begin
            for (int r = 0; r < 32; r++) ready_at[r] = 0;
            md_done = 0;
            e_tnew  = 0;
        end else if (m_stall) begin
            e_tnew = 0;
        end else begin
            decode(ir, dst, tnew, trs, trt, hilo, len);
            e_tnew = tnew;
            if (dst != 0 && cyc + 1 + tnew > ready_at[dst]) ready_at[dst] = cyc + 1 + tnew;
            if (len != 0) md_done = cyc + 1 + len;
        end
        cyc++;
    end

    always @(negedge clk) begin
        m_stall = model_stall();
        if (chk_en) begin
            check("stall", {31'd0, stall}, {31'd0, m_stall});
            check("md_busy", {31'd0, md_busy}, (cyc < md_done) ? 32'd1 : 32'd0);
            check("tnew_E", {30'd0, tnew_E}, 32'(e_tnew));
            if (stall === 1'b1) n_stall++;
            if (md_busy === 1'b1) n_busy++;
        end
    end

    function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'h0004};
    endfunction

    task automatic load2(input logic [31:0] a, input logic [31:0] b);
        prog.delete();
        prog.push_back(a);
        prog.push_back(b);
    endtask

    // Entered and left just after a rising edge; a negative expectation skips that literal check.
    task automatic run_prog(input string nm, input int reset_at, input int exp_stalls, input int exp_busy);
        int k, idx;
        bit adv;
        k = 0;
        idx = 0;
        n_stall = 0;
        n_busy = 0;
        ir = prog[0];
        while (idx < prog.size() + 12) begin
            @(posedge clk);
            adv = !m_stall && !rst;
            k++;
            #1;
            if (adv) idx++;
            ir  = (idx < prog.size()) ? prog[idx] : 32'h0;
            rst = (k == reset_at);
            if (k > 4000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_timeout: still at instruction %0d after %0d cycles", nm, idx, k);
                break;
            end
        end
        if (exp_stalls >= 0) check({nm, "_stalls"}, 32'(n_stall), 32'(exp_stalls));
        if (exp_busy >= 0) check({nm, "_busy"}, 32'(n_busy), 32'(exp_busy));
    endtask

    initial begin
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        ir = r_ins('h12, 0, 0, 3);
        @(negedge clk);
        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_md_busy", {31'd0, md_busy}, 32'd0);
        check("reset_tnew_E", {30'd0, tnew_E}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ir  = 32'h0;

        load2(i_ins('h23, 0, 1), r_ins('h21, 1, 1, 2));
        run_prog("lw_addu", -1, 1, 0);
        load2(i_ins('h23, 0, 1), i_ins('h04, 1, 0));
        run_prog("lw_beq", -1, 2, 0);
        load2(r_ins('h21, 2, 3, 1), i_ins('h04, 1, 0));
        run_prog("addu_beq", -1, 1, 0);
        load2(i_ins('h0f, 0, 1), i_ins('h04, 1, 0));
        run_prog("lui_beq", -1, 0, 0);
        load2(i_ins('h23, 0, 1), i_ins('h2b, 2, 1));
        run_prog("lw_sw_rt", -1, 0, 0);
        load2(i_ins('h23, 0, 2), i_ins('h2b, 2, 1));
        run_prog("lw_sw_rs", -1, 1, 0);
        load2(r_ins('h18, 1, 2, 0), r_ins('h12, 0, 0, 3));
        run_prog("mult_mflo", -1, MULT_N, MULT_N);
        load2(r_ins('h1a, 1, 2, 0), r_ins('h12, 0, 0, 3));
        run_prog("div_mflo", -1, DIV_N, DIV_N);
        load2(r_ins('h1a, 1, 2, 0), r_ins('h12, 0, 0, 3));
        run_prog("div_reset", 3, 2, 3);
        load2(r_ins('h21, 1, 1, 0), i_ins('h04, 0, 0));
        run_prog("dst_zero", -1, 0, 0);
        load2(i_ins('h03, 0, 0), r_ins('h08, 31, 0, 0));
        run_prog("jal_jr", -1, 0, 0);

        prog.delete();
        for (int n = 0; n < 150; n++) begin
            int a, b, c;
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            case ($urandom_range(0, 11))
                0, 1: prog.push_back(r_ins('h21, a, b, c));
                2:    prog.push_back(r_ins('h2a, a, b, c));
                3:    prog.push_back(i_ins('h0d, a, b));
                4, 5: prog.push_back(i_ins('h23, a, b));
                6:    prog.push_back(i_ins('h2b, a, b));
                7:    prog.push_back(i_ins('h04, a, b));
                8:    prog.push_back(i_ins('h0f, 0, b));
                9:    prog.push_back(r_ins(($urandom_range(0, 1) != 0) ? 'h18 : 'h1b, a, b, 0));
                10:   prog.push_back(r_ins('h12, 0, 0, c));
                default: prog.push_back(r_ins('h09, a, 0, c));
            endcase
        end
        run_prog("random", -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
